// File: rtl/drr_scheduler.sv
// Deficit-round-robin arbiter for the memory-request queues.
// Optional per-queue grant counters are built when DRR_STATS_EN is defined.
module drr_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 32
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] quanta,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] costs,
    input  logic [NUMBER_OF_QUEUES-1:0]                    empty,
    input  logic                                           flush,
    input  logic                                           ready,
    output logic                                           valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]            selection,
    output logic                                           grant,
    output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] grant_counts,
    output logic [1:0]                                     dbg_state
);

    localparam int PW = $clog2(NUMBER_OF_QUEUES);
    localparam int W  = REGISTER_SIZE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        SERVE   = 2'd2
    } state_t;

    state_t                            state, state_next;
    logic [PW-1:0]                     pointer;
    logic [NUMBER_OF_QUEUES-1:0][W-1:0] deficit;

    logic [W-1:0]  cur_cost;
    logic          found;
    logic [PW-1:0] next_q;
    logic [PW-1:0] idx_q;
    int            idx;
    logic [W:0]    sum;
    logic [W-1:0]  sat_deficit;

    // Handshake: valid is a pure function of state/empty/costs/deficit and never
    // looks at ready; a transaction is consumed on any cycle with valid & ready.
    assign cur_cost  = (costs[pointer] == '0) ? W'(1) : costs[pointer];
    assign valid     = (state == SERVE) && !empty[pointer] && (cur_cost <= deficit[pointer]);
    assign grant     = valid && ready;
    assign selection = pointer;
    assign dbg_state = state;

    // Rotating search starting just after pointer and wrapping back onto it.
    always_comb begin
        found  = 1'b0;
        next_q = pointer;
        idx    = 0;
        idx_q  = '0;
        for (int k = 1; k <= NUMBER_OF_QUEUES; k++) begin
            idx   = (int'(pointer) + k) % NUMBER_OF_QUEUES;
            idx_q = PW'(idx);
            if (!found && !empty[idx_q]) begin
                found  = 1'b1;
                next_q = idx_q;
            end
        end
    end

    assign sum         = {1'b0, deficit[next_q]} + {1'b0, quanta[next_q]};
    assign sat_deficit = sum[W] ? '1 : sum[W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!(&empty)) state_next = ADVANCE;
            ADVANCE: state_next = found ? SERVE : IDLE;
            SERVE:   if (!grant && !valid) state_next = ADVANCE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pointer <= PW'(NUMBER_OF_QUEUES - 1);
            deficit <= '0;
        end else if (flush) begin
            pointer <= PW'(NUMBER_OF_QUEUES - 1);
            deficit <= '0;
        end else begin
            case (state)
                ADVANCE: begin
                    if (found) begin
                        pointer         <= next_q;
                        deficit[next_q] <= sat_deficit;
                    end
                end
                SERVE: begin
                    if (grant)
                        deficit[pointer] <= deficit[pointer] - cur_cost;
                    else if (empty[pointer])
                        deficit[pointer] <= '0; // idle queue forfeits its credit
                end
                default: ;
            endcase
        end
    end

`ifdef DRR_STATS_EN
    logic [NUMBER_OF_QUEUES-1:0][W-1:0] counts;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     counts <= '0;
        else if (flush) counts <= '0;
        else if (grant) counts[pointer] <= counts[pointer] + W'(1);
    end

    assign grant_counts = counts;
`else
    assign grant_counts = '0;
`endif

endmodule

// File: tb/tb_drr_scheduler.sv
// Directed, table-driven bench for drr_scheduler: per-cycle expected
// valid/grant/selection/state plus hand-written flush and reset sequences.
module tb_drr_scheduler;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADV  = 2'd1;
    localparam logic [1:0] S_SRV  = 2'd2;

    logic             clock;
    logic             reset;
    logic [3:0][31:0] quanta;
    logic [3:0][31:0] costs;
    logic [3:0]       empty;
    logic             flush;
    logic             ready;
    logic             valid;
    logic [1:0]       selection;
    logic             grant;
    logic [3:0][31:0] grant_counts;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] empty;
        logic       ready;
        logic       flush;
        logic       exp_valid;
        logic       exp_grant;
        logic [1:0] exp_sel;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl[$];

    drr_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .quanta       (quanta),
        .costs        (costs),
        .empty        (empty),
        .flush        (flush),
        .ready        (ready),
        .valid        (valid),
        .selection    (selection),
        .grant        (grant),
        .grant_counts (grant_counts),
        .dbg_state    (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(logic [3:0] e, logic r, logic f, logic v, logic g,
                                logic [1:0] s, logic [1:0] st);
        vec_t t;
        t.empty = e; t.ready = r; t.flush = f;
        t.exp_valid = v; t.exp_grant = g; t.exp_sel = s; t.exp_state = st;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, check combinational outputs, advance one cycle.
    task automatic step(input vec_t v, input string tag);
        empty = v.empty;
        ready = v.ready;
        flush = v.flush;
        #1;
        chk({tag, ".valid"}, 32'(valid), 32'(v.exp_valid));
        chk({tag, ".grant"}, 32'(grant), 32'(v.exp_grant));
        chk({tag, ".selection"}, 32'(selection), 32'(v.exp_sel));
        chk({tag, ".state"}, 32'(dbg_state), 32'(v.exp_state));
        @(negedge clock);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s[%0d]", tag, i));
        tbl.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        empty = 4'hF;
        ready = 1'b0;
        flush = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        quanta = '0;
        costs  = '0;
        do_reset();

        // All empty after reset, then q0/q2 alternate with quantum 4, cost 1.
        quanta = {32'd4, 32'd4, 32'd4, 32'd4};
        costs  = {32'd1, 32'd1, 32'd1, 32'd1};
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'hF, 1, 0, 0, 0, 3, S_IDLE));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 3, S_IDLE));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 3, S_ADV));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(4'b1010, 1, 0, 1, 1, 0, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 0, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 0, S_ADV));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(4'b1010, 1, 0, 1, 1, 2, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 2, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 2, S_ADV));
        tbl.push_back(mk(4'b1010, 1, 0, 1, 1, 0, S_SRV));
        run_table("rr");

        // Quantum 3, cost 2 on q0 only: residual deficit carries to the next round.
        do_reset();
        quanta = {32'd0, 32'd0, 32'd0, 32'd3};
        costs  = {32'd1, 32'd1, 32'd1, 32'd2};
        tbl.push_back(mk(4'b1110, 1, 0, 0, 0, 3, S_IDLE));
        tbl.push_back(mk(4'b1110, 1, 0, 0, 0, 3, S_ADV));
        tbl.push_back(mk(4'b1110, 1, 0, 1, 1, 0, S_SRV));
        tbl.push_back(mk(4'b1110, 1, 0, 0, 0, 0, S_SRV));
        tbl.push_back(mk(4'b1110, 1, 0, 0, 0, 0, S_ADV));
        tbl.push_back(mk(4'b1110, 1, 0, 1, 1, 0, S_SRV));
        tbl.push_back(mk(4'b1110, 1, 0, 1, 1, 0, S_SRV));
        tbl.push_back(mk(4'b1110, 1, 0, 0, 0, 0, S_SRV));
        tbl.push_back(mk(4'b1110, 1, 0, 0, 0, 0, S_ADV));
        tbl.push_back(mk(4'b1110, 1, 0, 1, 1, 0, S_SRV));
        run_table("resid");

        // Asynchronous reset while q0 is being served.
        reset = 1'b0;
        #1;
        chk("async_rst.valid", 32'(valid), 32'd0);
        chk("async_rst.selection", 32'(selection), 32'd3);
        chk("async_rst.state", 32'(dbg_state), 32'(S_IDLE));
        @(negedge clock);
        reset = 1'b1;

        // q1 holding deficit 5 with ready=0, then goes empty: credit is forfeited.
        do_reset();
        quanta = {32'd0, 32'd0, 32'd5, 32'd0};
        costs  = {32'd1, 32'd1, 32'd1, 32'd1};
        step(mk(4'b1101, 0, 0, 0, 0, 3, S_IDLE), "forfeit0");
        step(mk(4'b1101, 0, 0, 0, 0, 3, S_ADV), "forfeit1");
        step(mk(4'b1101, 0, 0, 1, 0, 1, S_SRV), "forfeit2");
        step(mk(4'b1101, 0, 0, 1, 0, 1, S_SRV), "forfeit3");
        step(mk(4'b1111, 0, 0, 0, 0, 1, S_SRV), "forfeit4");
        step(mk(4'b1111, 0, 0, 0, 0, 1, S_ADV), "forfeit5");
        quanta[1] = 32'd1;
        costs[1]  = 32'd2;
        step(mk(4'b1101, 1, 0, 0, 0, 1, S_IDLE), "forfeit6");
        step(mk(4'b1101, 1, 0, 0, 0, 1, S_ADV), "forfeit7");
        step(mk(4'b1101, 1, 0, 0, 0, 1, S_SRV), "forfeit8");

        // Saturation: two visits of 0xC0000000 clamp to all-ones and cover cost 0xFFFFFFFF.
        do_reset();
        quanta = {32'd0, 32'hC000_0000, 32'd0, 32'd1};
        costs  = {32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1};
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 3, S_IDLE));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 3, S_ADV));
        tbl.push_back(mk(4'b1010, 1, 0, 1, 1, 0, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 0, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 0, S_ADV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 2, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 2, S_ADV));
        tbl.push_back(mk(4'b1010, 1, 0, 1, 1, 0, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 0, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 0, S_ADV));
        tbl.push_back(mk(4'b1010, 1, 0, 1, 1, 2, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 2, S_SRV));
        tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 2, S_ADV));
        tbl.push_back(mk(4'b1010, 1, 0, 1, 1, 0, S_SRV));
        run_table("sat");

        // Flush during a q1 grant: grant still visible, deficits and counters cleared.
        do_reset();
        quanta = {32'd0, 32'd0, 32'd4, 32'd0};
        costs  = {32'd1, 32'd1, 32'd1, 32'd1};
        step(mk(4'b1101, 1, 0, 0, 0, 3, S_IDLE), "flush0");
        step(mk(4'b1101, 1, 0, 0, 0, 3, S_ADV), "flush1");
        step(mk(4'b1101, 1, 0, 1, 1, 1, S_SRV), "flush2");
`ifdef DRR_STATS_EN
        chk("stats.before_flush", grant_counts[1], 32'd1);
`endif
        step(mk(4'b1101, 1, 1, 1, 1, 1, S_SRV), "flush3");
        costs[1] = 32'd5;
        chk("stats.after_flush0", grant_counts[0], 32'd0);
        chk("stats.after_flush1", grant_counts[1], 32'd0);
        step(mk(4'b1101, 1, 0, 0, 0, 3, S_IDLE), "flush4");
        step(mk(4'b1101, 1, 0, 0, 0, 3, S_ADV), "flush5");
        step(mk(4'b1101, 1, 0, 0, 0, 1, S_SRV), "flush6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
